// File: rtl/nested_loop_ctrl.sv
// rtl/nested_loop_ctrl.sv - nested odometer loop-index generator with per-job latched bounds
//
// Produces NUM_LVL nested 1-based loop indices (level 0 innermost). A job is
// launched by start in IDLE, which latches the per-level trip counts. The job
// then advances one tuple per accepted step until the final tuple is consumed.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - synchronous enable; low aborts any job back to IDLE
//   start    - job start pulse, honoured in IDLE only
//   bound    - per-level trip counts, level k at [k*IW +: IW]
//   step     - consumer accepts the current index tuple
//   idx      - current indices, same packing as bound
//   valid    - idx holds a live iteration
//   lvl_last - lvl_last[k] set when levels 0..k all sit at their bound
//   busy     - a job is running
//   done     - one-cycle pulse after the final tuple (or an empty job)
module nested_loop_ctrl #(
  parameter int NUM_LVL = 3,
  parameter int IW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [NUM_LVL*IW-1:0] bound,
  input  logic                  step,
  output logic [NUM_LVL*IW-1:0] idx,
  output logic                  valid,
  output logic [NUM_LVL-1:0]    lvl_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [IW-1:0]         ONE      = IW'(1);
  localparam logic [NUM_LVL*IW-1:0] IDX_INIT = {NUM_LVL{ONE}};

  state_t                state;
  logic [NUM_LVL*IW-1:0] bound_q;
  logic [NUM_LVL*IW-1:0] idx_next;
  logic [NUM_LVL-1:0]    at_max;
  logic [NUM_LVL-1:0]    zero_fld;

  // Odometer: a level advances only when every level below it is at its
  // bound; a level that is itself at its bound wraps back to 1.
  for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
    assign at_max[k]   = idx[k*IW +: IW] == bound_q[k*IW +: IW];
    assign zero_fld[k] = bound[k*IW +: IW] == '0;
    assign lvl_last[k] = &at_max[k:0];

    if (k == 0) begin : g_inner
      assign idx_next[k*IW +: IW] = at_max[k] ? ONE : idx[k*IW +: IW] + ONE;
    end else begin : g_outer
      assign idx_next[k*IW +: IW] = !(&at_max[k-1:0]) ? idx[k*IW +: IW] :
                                    at_max[k]         ? ONE :
                                                        idx[k*IW +: IW] + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= IDX_INIT;
      bound_q <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      idx     <= IDX_INIT;
      bound_q <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bound_q <= bound;
            if (|zero_fld) begin
              // Empty job: report completion without ever presenting a tuple.
              done <= 1'b1;
            end else begin
              state <= RUN;
              idx   <= IDX_INIT;
              valid <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (step) begin
            if (lvl_last[NUM_LVL-1]) begin
              state <= IDLE;
              idx   <= IDX_INIT;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nested_loop_ctrl.sv
// tb/tb_nested_loop_ctrl.sv - self-checking bench for nested_loop_ctrl
module tb_nested_loop_ctrl;

  localparam int NL = 3;
  localparam int IW = 5;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b0;
  logic              start = 1'b0;
  logic              step  = 1'b0;
  logic [NL*IW-1:0]  bound = '0;
  logic [NL*IW-1:0]  idx;
  logic              valid;
  logic [NL-1:0]     lvl_last;
  logic              busy;
  logic              done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: job described by its bounds and a linear iteration count.
  int m_b[NL];
  bit m_run;
  bit m_done;
  int m_n;
  int accepted;

  always #5 clk = ~clk;

  nested_loop_ctrl #(.NUM_LVL(NL), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .bound(bound),
    .step(step), .idx(idx), .valid(valid), .lvl_last(lvl_last),
    .busy(busy), .done(done)
  );

  function automatic int total();
    int p = 1;
    for (int k = 0; k < NL; k++) p = p * m_b[k];
    return p;
  endfunction

  // Iteration n maps to mixed-radix digits of n (radix = bounds), plus one.
  function automatic logic [NL*IW-1:0] exp_idx();
    logic [NL*IW-1:0] e;
    int div = 1;
    for (int k = 0; k < NL; k++) begin
      if (m_run) e[k*IW +: IW] = IW'((m_n / div) % m_b[k] + 1);
      else       e[k*IW +: IW] = IW'(1);
      if (m_run) div = div * m_b[k];
    end
    return e;
  endfunction

  function automatic logic [NL-1:0] exp_last(input logic [NL*IW-1:0] e);
    logic [NL-1:0] r;
    bit all_max = 1'b1;
    for (int k = 0; k < NL; k++) begin
      all_max = all_max && (int'(e[k*IW +: IW]) == m_b[k]);
      r[k] = all_max;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [NL*IW-1:0] e;
    e = exp_idx();
    check({ctx, ".idx"}, 32'(idx), 32'(e));
    check({ctx, ".valid"}, 32'(valid), 32'(m_run));
    check({ctx, ".busy"}, 32'(busy), 32'(m_run));
    check({ctx, ".done"}, 32'(done), 32'(m_done));
    check({ctx, ".lvl_last"}, 32'(lvl_last), 32'(exp_last(e)));
  endtask

  task automatic model_clear();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_n    = 0;
    for (int k = 0; k < NL; k++) m_b[k] = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit any_zero;
    if (!rst_n || !en) begin
      model_clear();
    end else if (!m_run) begin
      m_done = 1'b0;
      if (start) begin
        any_zero = 1'b0;
        for (int k = 0; k < NL; k++) begin
          m_b[k] = int'(bound[k*IW +: IW]);
          if (m_b[k] == 0) any_zero = 1'b1;
        end
        if (any_zero) m_done = 1'b1;
        else begin
          m_run    = 1'b1;
          m_n      = 0;
          accepted = 0;
        end
      end
    end else begin
      m_done = 1'b0;
      if (step) begin
        m_n++;
        accepted++;
        if (m_n == total()) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic set_bound(input int b2, input int b1, input int b0);
    bound = {IW'(b2), IW'(b1), IW'(b0)};
  endtask

  task automatic rand_bound();
    for (int k = 0; k < NL; k++) bound[k*IW +: IW] = IW'($urandom_range(1, 4));
    if ($urandom % 8 == 0) bound[($urandom % NL)*IW +: IW] = '0;
  endtask

  int stall_seq[5] = '{1, 2, 2, 2, 3};
  int stall_stp[5] = '{1, 0, 0, 1, 1};
  int mx;

  initial begin
    accepted = 0;
    model_clear();
    @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    cyc("idle");

    // Full sweep {2,3,4}
    set_bound(2, 3, 4);
    start = 1'b1;
    cyc("sweep_start");
    check("sweep_first_valid", 32'(valid), 32'd1);
    start = 1'b0;
    step  = 1'b1;
    for (int i = 0; i < 40 && !m_done; i++) cyc("sweep");
    check("sweep_steps", 32'(accepted), 32'd24);
    check("sweep_done_valid", 32'(valid), 32'd0);
    step = 1'b0;
    cyc("sweep_after");

    // Stall {1,1,3}
    set_bound(1, 1, 3);
    start = 1'b1;
    cyc("stall_start");
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_idx0", 32'(idx[IW-1:0]), 32'(stall_seq[i]));
      step = stall_stp[i][0];
      cyc("stall");
    end
    check("stall_done", 32'(done), 32'd1);
    step = 1'b0;
    cyc("stall_after");

    // Empty job {2,0,5}
    set_bound(2, 0, 5);
    start = 1'b1;
    cyc("empty");
    start = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_valid", 32'(valid), 32'd0);
    cyc("empty_after");

    // Abort {3,3,3}
    set_bound(3, 3, 3);
    start = 1'b1;
    cyc("abort_start");
    start = 1'b0;
    step  = 1'b1;
    for (int i = 0; i < 4; i++) cyc("abort_run");
    step = 1'b0;
    en   = 1'b0;
    cyc("abort");
    check("abort_idx", 32'(idx), 32'h0421);
    check("abort_done", 32'(done), 32'd0);
    en = 1'b1;
    cyc("abort_after");

    // Start during RUN ignored
    set_bound(3, 3, 3);
    start = 1'b1;
    cyc("ign_start");
    start = 1'b0;
    step  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      set_bound(7, 1, 9);
      cyc("ign_run");
    end
    start = 1'b0;
    for (int i = 0; i < 40 && !m_done; i++) cyc("ign_tail");
    check("ign_steps", 32'(accepted), 32'd27);

    // Max bound then back-to-back start in the done cycle
    set_bound(1, 1, 31);
    start = 1'b1;
    cyc("max_start");
    start = 1'b0;
    mx = 0;
    for (int i = 0; i < 40 && !m_done; i++) begin
      if (int'(idx[IW-1:0]) > mx) mx = int'(idx[IW-1:0]);
      cyc("max");
    end
    check("max_idx0", 32'(mx), 32'd31);
    check("max_done", 32'(done), 32'd1);
    set_bound(2, 1, 2);
    start = 1'b1;
    cyc("b2b_start");
    start = 1'b0;
    check("b2b_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 20 && !m_done; i++) cyc("b2b");
    check("b2b_steps", 32'(accepted), 32'd4);
    step = 1'b0;
    cyc("b2b_after");

    // Asynchronous reset mid-job
    set_bound(2, 3, 4);
    start = 1'b1;
    cyc("rst_start");
    start = 1'b0;
    step  = 1'b1;
    for (int i = 0; i < 5; i++) cyc("rst_run");
    step = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    cyc("rst_hold");
    rst_n = 1'b1;
    cyc("rst_release");

    // Randomised jobs with stalls, stray starts and occasional aborts
    for (int j = 0; j < 30; j++) begin
      rand_bound();
      start = 1'b1;
      step  = 1'b0;
      cyc("rnd_start");
      start = 1'b0;
      for (int i = 0; i < 200 && m_run; i++) begin
        step  = ($urandom % 4) != 0;
        start = ($urandom % 6) == 0;
        rand_bound();
        en    = ($urandom % 60) != 0;
        cyc("rnd");
      end
      en    = 1'b1;
      start = 1'b0;
      step  = 1'b0;
      cyc("rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nested_loop_ctrl.md
Name: nested_loop_ctrl

Overview:
- Parametrised successor of the single-level loop counter.
- Generates NUM_LVL nested 1-based loop indices with run-time bounds latched per job.
- Advances one iteration per accepted step and flags per-level wrap and job completion.
- Sits between the layer sequencer and the LSTM/FC datapath address generators, driving gate/timestep/neuron loop indices.

Parameters:
- NUM_LVL, 3, number of nested loop levels; level 0 is innermost (fastest).
- IW, 5, width of each index and each bound.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  synchronous enable; 0 aborts any job to IDLE
- start  input  1  job start pulse, sampled in IDLE only
- bound  input  NUM_LVL*IW  per-level trip count; level k at bits [k*IW +: IW]; sampled on accepted start
- step  input  1  consumer accepts current index tuple; advance
- idx  output  NUM_LVL*IW  current indices, same packing as bound; each 1..bound[k]
- valid  output  1  idx holds a live iteration
- lvl_last  output  NUM_LVL  lvl_last[k]=1 when idx[k]==bound[k] and lvl_last[k-1]=1 (lvl_last[0] = idx[0]==bound[0])
- busy  output  1  state is RUN
- done  output  1  one-cycle pulse after the final iteration is accepted

Behaviour:
- Clock and reset: single clock clk, rising edge. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state IDLE, every idx field=1, latched bounds=0, valid=0, done=0, busy=0.
- en=0 at a clock edge (rst_n=1): same values as reset, applied synchronously; no done pulse; start and step ignored.
- State machine: IDLE, RUN.
- IDLE, en=1, start=1:
  - Latch bound.
  - If any bound field==0: stay IDLE, done=1 for one cycle, valid stays 0 (empty job).
  - Else: next cycle state RUN, all idx=1, valid=1, busy=1.
- Start latency: one cycle from start to first valid.
- RUN, step=0: idx and valid hold.
- RUN, step=1, lvl_last[NUM_LVL-1]=0:
  - Odometer increment: level 0 increments.
  - Any level k with lvl_last[k]=1 wraps to 1; the level above it increments.
  - valid stays 1.
- RUN, step=1, lvl_last[NUM_LVL-1]=1 (final tuple accepted):
  - Next cycle state IDLE, valid=0, busy=0, all idx=1, done=1 for exactly that cycle.
- start in RUN: ignored, with no effect on bounds or indices.
- start coinciding with the done cycle (IDLE with done=1): accepted as a new job. Back-to-back jobs have a one-cycle valid gap.
- Bounds are held internally for the whole job; changes on the bound input during RUN have no effect.
- Arithmetic:
  - Unsigned, per-level IW bits.
  - An index never exceeds its latched bound, so no overflow (bound=2^IW-1 is legal).
  - lvl_last and idx are driven from registered state; lvl_last is combinational from registers, with no extra latency.
- Total iterations per job: product of the bounds. Accepted steps equal that product exactly.

Test Plan:
- Reset mid-job: NUM_LVL=3, IW=5, bound={2,3,4} (lvl2,lvl1,lvl0), 5 steps, then rst_n=0 -> idx all 1, valid=0, busy=0 immediately, without waiting for a clock edge; no done.
- Full sweep: bound={2,3,4}, start, step held 1 -> valid one cycle after start.
  - idx0 runs 1..4 and wraps; idx1 runs 1..3; idx2 runs 1..2.
  - 24 valid tuples, last tuple {2,3,4} with lvl_last=3'b111.
  - done pulses the cycle after the 24th step; valid=0 in that cycle.
- Stall: bound={1,1,3}, step toggled 1,0,0,1,1 -> idx0 sequence 1,2,2,2,3 then done; idx holds during step=0.
- Empty job: bound={2,0,5}, start -> valid never asserts; done=1 one cycle after start; state IDLE.
- Abort and ignored start: bound={3,3,3}, 4 steps, en=0 for one cycle -> next edge idx=1s, valid=0, no done.
  - start during RUN with different bounds -> ignored, sequence unchanged.
- Max bound and back-to-back: bound={1,1,31} -> idx0 reaches 31 without overflow; done.
  - start asserted in the done cycle -> new job's first valid on the following cycle.
